output_pkg_packer: RTL and testbench
====================================

// Module: output_pkg_packer
// PURPOSE
//  Sits directly upstream of the output memory. It collects 64-bit result beats from the
//  Winograd PE array and packs each run of 8 beats into one 512-bit package.
//  Packages are issued in pairs on the memory's two write ports (addr/data/valid 1 and 2).
//  Addresses are sequential from a base address latched at start.
// PARAMETERS
//  BEAT_W         64   width of one input beat
//  BEATS_PER_PKG  8    beats per package; BEAT_W*BEATS_PER_PKG = 512
//  ADDR_W         8    output memory address width
// PORTS
//  clk                  in   1    controller clock; all logic on rising edge
//  reset                in   1    synchronous, active-high
//  start                in   1    1-cycle pulse; begins a job (ignored unless IDLE)
//  base_addr            in   8    address of first package, latched on accepted start
//  num_pkgs             in   9    packages in job, 0..256; values >256 treated as 256
//  beat_valid_in        in   1    beat_in valid
//  beat_in              in   64   result beat
//  beat_ready_out       out  1    beat accepted when beat_valid_in & beat_ready_out
//  addr_1_out           out  8    port-1 package address
//  addr_2_out           out  8    port-2 package address
//  data_1_out           out  512  port-1 package
//  data_2_out           out  512  port-2 package
//  package_1_valid_out  out  1    port-1 write strobe, 1-cycle pulse
//  package_2_valid_out  out  1    port-2 write strobe, 1-cycle pulse
//  busy                 out  1    high while in RUN
//  done                 out  1    1-cycle pulse at job end
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; beat/package counters cleared; partial beats discarded.
//  FSM: IDLE --start&num_pkgs!=0--> RUN (latch base, count)
//       IDLE --start&num_pkgs==0--> DONE
//       RUN --last package issued--> IDLE, with done pulsed in the issuing cycle
//       DONE --> IDLE, with done=1 for exactly that one cycle
//  start outside IDLE: ignored.
//  beat_ready_out = 1 only in RUN. No backpressure from memory; every package issues.
//  Packing: beat j (j=0 first) of a package -> bits [64j+63:64j].
//    The 3-bit beat counter wraps 7->0 on package completion.
//  Package k (0-based) is slot 1 if k even, slot 2 if k odd.
//  A completed slot-1 package waits in its buffer until the slot-2 package completes.
//  Pair issue: the cycle after the 8th beat of the odd package is accepted, both outputs
//    are registered with addr_1_out=base+k-1 and addr_2_out=base+k.
//    package_1_valid_out and package_2_valid_out are both 1 for that single cycle.
//  Odd tail: if the final package is even-indexed, it issues alone the cycle after its 8th
//    beat. package_1_valid_out=1, package_2_valid_out=0, addr_2_out/data_2_out unchanged.
//  Output registers are separate from the assembly buffers.
//    Beat acceptance continues in the issue cycle, so there are no bubbles.
//  Address arithmetic: 8-bit, modulo 256 (0xFF+1 = 0x00).
//  Beats offered after the last package are not accepted (ready drops with the issue cycle).
//  addr/data outputs hold their last value after valid falls. valid is never held >1 cycle.
//  Reset mid-job: immediate return to IDLE. No package or done is issued for the aborted job.
//  Latency: last accepted beat -> package valid = 1 cycle. done coincides with the final valid.
// TESTING
//  1 Hold reset 2 cycles -> all outputs 0, beat_ready_out=0, busy=0, done=0.
//  2 start base=0x05 num=2; beats 0..15 back-to-back, value=i ->
//      1 cycle after beat 15: valid1=valid2=1, addr 0x05/0x06, done=1;
//      data_1_out={64'd7,...,64'd0}, data_2_out={64'd15,...,64'd8}.
//  3 start base=0xFE num=3; 24 beats -> pair at 0xFE/0xFF;
//      then port-1 only at 0x00 with valid2=0 and done=1.
//  4 As test 2 with beat_valid_in toggling every cycle -> identical packages/addresses.
//      Issue occurs 1 cycle after the 16th accepted beat.
//  5 Reset after 5 beats of a num=2 job, then new start base=0x20 num=2 ->
//      no valid from the aborted job; new pair at 0x20/0x21 holds only new beats.
//  6 start num=0 -> done 1 cycle later, no valid.
//      start pulsed mid-RUN -> ignored, base/count unchanged.

Source files
------------

// File: rtl/output_pkg_packer_if.sv
// Bus between the Winograd result stream, the packer and the output memory's two write ports.
// Job control, beat stream and both package ports share one interface.
interface output_pkg_packer_if #(
    parameter int BEAT_W        = 64,
    parameter int BEATS_PER_PKG = 8,
    parameter int ADDR_W        = 8
);
    localparam int PKG_W = BEAT_W * BEATS_PER_PKG;

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_pkgs;
    logic              beat_valid_in;
    logic [BEAT_W-1:0] beat_in;
    logic              beat_ready_out;
    logic [ADDR_W-1:0] addr_1_out;
    logic [ADDR_W-1:0] addr_2_out;
    logic [PKG_W-1:0]  data_1_out;
    logic [PKG_W-1:0]  data_2_out;
    logic              package_1_valid_out;
    logic              package_2_valid_out;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, num_pkgs, beat_valid_in, beat_in,
        input  beat_ready_out, addr_1_out, addr_2_out, data_1_out, data_2_out,
               package_1_valid_out, package_2_valid_out, busy, done
    );

    modport slave (
        input  start, base_addr, num_pkgs, beat_valid_in, beat_in,
        output beat_ready_out, addr_1_out, addr_2_out, data_1_out, data_2_out,
               package_1_valid_out, package_2_valid_out, busy, done
    );
endinterface

// File: rtl/output_pkg_packer.sv
// Packs runs of BEATS_PER_PKG result beats into packages and issues them in pairs
// on the output memory's two write ports, addresses sequential from a latched base.
module output_pkg_packer #(
    parameter int BEAT_W        = 64,
    parameter int BEATS_PER_PKG = 8,
    parameter int ADDR_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output_pkg_packer_if.slave   bus
);
    localparam int CNT_W = $clog2(BEATS_PER_PKG);
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] MAX_PKGS = IDX_W'(1 << ADDR_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                  state, state_nxt;
    logic [CNT_W-1:0]                        beat_cnt;
    logic [IDX_W-1:0]                        pkg_idx, pkg_total;
    logic [ADDR_W-1:0]                       base_q, pkg_addr;
    logic [BEATS_PER_PKG-1:0][BEAT_W-1:0]    asm_buf, pkg_full, hold_buf;
    logic [BEATS_PER_PKG-1:0][BEAT_W-1:0]    data_1_q, data_2_q;
    logic [ADDR_W-1:0]                       addr_1_q, addr_2_q;
    logic                                    vld_1_q, vld_2_q, done_q;
    logic                                    accept, pkg_done, last_pkg;

    assign accept   = (state == RUN) && bus.beat_valid_in;
    assign pkg_done = accept && (beat_cnt == CNT_W'(BEATS_PER_PKG - 1));
    assign last_pkg = pkg_done && (pkg_idx == pkg_total - IDX_W'(1));
    assign pkg_addr = base_q + pkg_idx[ADDR_W-1:0];

    // Package as it will look once the beat on the bus lands in its lane.
    for (genvar g = 0; g < BEATS_PER_PKG; g++) begin : g_lane
        assign pkg_full[g] = (beat_cnt == CNT_W'(g)) ? bus.beat_in : asm_buf[g];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.num_pkgs == '0) ? DONE : RUN;
            RUN:     if (last_pkg)  state_nxt = IDLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt  <= '0;
            pkg_idx   <= '0;
            pkg_total <= '0;
            base_q    <= '0;
            asm_buf   <= '0;
            hold_buf  <= '0;
            data_1_q  <= '0;
            data_2_q  <= '0;
            addr_1_q  <= '0;
            addr_2_q  <= '0;
            vld_1_q   <= 1'b0;
            vld_2_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vld_1_q <= 1'b0;
            vld_2_q <= 1'b0;
            done_q  <= 1'b0;
            if (state == IDLE && bus.start) begin
                if (bus.num_pkgs == '0) begin
                    done_q <= 1'b1;
                end else begin
                    base_q    <= bus.base_addr;
                    pkg_total <= (bus.num_pkgs > MAX_PKGS) ? MAX_PKGS : bus.num_pkgs;
                    pkg_idx   <= '0;
                    beat_cnt  <= '0;
                end
            end
            if (accept) begin
                asm_buf  <= pkg_full;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            // Odd package closes a pair; even package parks in hold_buf unless it is the tail.
            if (pkg_done) begin
                pkg_idx <= pkg_idx + IDX_W'(1);
                if (pkg_idx[0]) begin
                    data_1_q <= hold_buf;
                    data_2_q <= pkg_full;
                    addr_1_q <= pkg_addr - ADDR_W'(1);
                    addr_2_q <= pkg_addr;
                    vld_1_q  <= 1'b1;
                    vld_2_q  <= 1'b1;
                end else begin
                    hold_buf <= pkg_full;
                    if (last_pkg) begin
                        data_1_q <= pkg_full;
                        addr_1_q <= pkg_addr;
                        vld_1_q  <= 1'b1;
                    end
                end
                if (last_pkg) done_q <= 1'b1;
            end
        end
    end

    assign bus.beat_ready_out      = (state == RUN);
    assign bus.busy                = (state == RUN);
    assign bus.done                = done_q;
    assign bus.package_1_valid_out = vld_1_q;
    assign bus.package_2_valid_out = vld_2_q;
    assign bus.addr_1_out          = addr_1_q;
    assign bus.addr_2_out          = addr_2_q;
    assign bus.data_1_out          = data_1_q;
    assign bus.data_2_out          = data_2_q;
endmodule

// File: tb/tb_output_pkg_packer.sv
// Bench for output_pkg_packer: queue-based job model compared every cycle, plus literal checks.
module tb_output_pkg_packer;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    output_pkg_packer_if bus ();
    output_pkg_packer dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: a job is a list of accepted beats; package k is beats 8k..8k+7.
    logic [63:0]  beats[$];
    bit           m_run, m_dn, was_dn;
    logic [7:0]   m_base;
    int           m_total, k;
    logic         e_v1, e_v2, e_done;
    logic [7:0]   e_a1, e_a2;
    logic [511:0] e_d1, e_d2;

    function automatic logic [511:0] pkg_of(int idx);
        logic [511:0] d;
        for (int j = 0; j < 8; j++) d[64*j +: 64] = beats[8*idx + j];
        return d;
    endfunction

    function automatic logic [511:0] pkg_lit(int first);
        logic [511:0] d;
        for (int j = 0; j < 8; j++) d[64*j +: 64] = 64'(first + j);
        return d;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_dn = 0;
            e_v1 = 0; e_v2 = 0; e_done = 0; e_a1 = 0; e_a2 = 0; e_d1 = 0; e_d2 = 0;
            beats.delete();
        end else begin
            was_dn = m_dn;
            m_dn = 0; e_v1 = 0; e_v2 = 0; e_done = 0;
            if (m_run) begin
                if (bus.beat_valid_in) begin
                    beats.push_back(bus.beat_in);
                    if (beats.size() % 8 == 0) begin
                        k = beats.size() / 8 - 1;
                        if (k % 2 == 1) begin
                            e_v1 = 1; e_v2 = 1;
                            e_a1 = m_base + 8'(k - 1); e_a2 = m_base + 8'(k);
                            e_d1 = pkg_of(k - 1);      e_d2 = pkg_of(k);
                        end else if (k == m_total - 1) begin
                            e_v1 = 1; e_a1 = m_base + 8'(k); e_d1 = pkg_of(k);
                        end
                        if (k == m_total - 1) begin
                            e_done = 1; m_run = 0;
                        end
                    end
                end
            end else if (!was_dn && bus.start) begin
                if (bus.num_pkgs == 0) begin
                    e_done = 1; m_dn = 1;
                end else begin
                    m_run = 1; m_base = bus.base_addr;
                    m_total = (bus.num_pkgs > 256) ? 256 : int'(bus.num_pkgs);
                    beats.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",  512'(bus.beat_ready_out),      512'(m_run));
            chk("busy",   512'(bus.busy),                512'(m_run));
            chk("done",   512'(bus.done),                512'(e_done));
            chk("valid1", 512'(bus.package_1_valid_out), 512'(e_v1));
            chk("valid2", 512'(bus.package_2_valid_out), 512'(e_v2));
            chk("addr1",  512'(bus.addr_1_out),          512'(e_a1));
            chk("addr2",  512'(bus.addr_2_out),          512'(e_a2));
            chk("data1",  bus.data_1_out,                e_d1);
            chk("data2",  bus.data_2_out,                e_d2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(logic [7:0] base, logic [8:0] num);
        bus.start = 1'b1; bus.base_addr = base; bus.num_pkgs = num;
        step();
        bus.start = 1'b0;
    endtask

    // Returns at posedge+1 of the edge that accepted the beat.
    task automatic send_beat(logic [63:0] v, int gap);
        bit acc = 1'b0;
        bus.beat_valid_in = 1'b0;
        repeat (gap) step();
        bus.beat_valid_in = 1'b1; bus.beat_in = v;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = bus.beat_ready_out;
            step();
        end
        bus.beat_valid_in = 1'b0;
        if (!acc) begin
            errors++; checks++;
            $display("FAIL beat_accept_timeout: beat %0h not accepted in 50 cycles", v);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_pkgs = '0;
        bus.beat_valid_in = 1'b0; bus.beat_in = '0;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_ready", 512'(bus.beat_ready_out), 512'(0));
        chk("rst_busy",  512'(bus.busy),           512'(0));
        chk("rst_done",  512'(bus.done),           512'(0));
        chk("rst_v1",    512'(bus.package_1_valid_out | bus.package_2_valid_out), 512'(0));
        chk("rst_data",  bus.data_1_out | bus.data_2_out, 512'(0));
        reset = 1'b0;
        step();

        // Pair at 0x05/0x06, back-to-back beats.
        pulse_start(8'h05, 9'd2);
        chk("t2_ready", 512'(bus.beat_ready_out), 512'(1));
        for (int i = 0; i < 16; i++) send_beat(64'(i), 0);
        chk("t2_v",     512'({bus.package_1_valid_out, bus.package_2_valid_out, bus.done}), 512'(3'b111));
        chk("t2_addr",  512'({bus.addr_1_out, bus.addr_2_out}), 512'(16'h0506));
        chk("t2_d1",    bus.data_1_out, pkg_lit(0));
        chk("t2_d2",    bus.data_2_out, pkg_lit(8));
        chk("t2_ready_drop", 512'(bus.beat_ready_out), 512'(0));
        step(); step();

        // Address wrap and odd tail.
        pulse_start(8'hFE, 9'd3);
        for (int i = 0; i < 16; i++) send_beat(64'(i), 0);
        chk("t3_pair_addr", 512'({bus.addr_1_out, bus.addr_2_out}), 512'(16'hFEFF));
        for (int i = 16; i < 24; i++) send_beat(64'(i), 0);
        chk("t3_tail_v",    512'({bus.package_1_valid_out, bus.package_2_valid_out, bus.done}), 512'(3'b101));
        chk("t3_tail_addr", 512'({bus.addr_1_out, bus.addr_2_out}), 512'(16'h00FF));
        chk("t3_tail_d1",   bus.data_1_out, pkg_lit(16));
        chk("t3_hold_d2",   bus.data_2_out, pkg_lit(8));
        step();

        // Toggling valid.
        pulse_start(8'h05, 9'd2);
        for (int i = 0; i < 16; i++) send_beat(64'(i), 1);
        chk("t4_v",    512'({bus.package_1_valid_out, bus.package_2_valid_out}), 512'(2'b11));
        chk("t4_addr", 512'({bus.addr_1_out, bus.addr_2_out}), 512'(16'h0506));
        chk("t4_d1",   bus.data_1_out, pkg_lit(0));
        chk("t4_d2",   bus.data_2_out, pkg_lit(8));
        step();

        // Reset mid-job then a fresh job.
        pulse_start(8'h10, 9'd2);
        for (int i = 0; i < 5; i++) send_beat(64'(1000 + i), 0);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_rst_busy", 512'(bus.busy), 512'(0));
        pulse_start(8'h20, 9'd2);
        for (int i = 0; i < 16; i++) send_beat(64'(100 + i), 0);
        chk("t5_addr", 512'({bus.addr_1_out, bus.addr_2_out}), 512'(16'h2021));
        chk("t5_d1",   bus.data_1_out, pkg_lit(100));
        chk("t5_d2",   bus.data_2_out, pkg_lit(108));
        step();

        // Empty job, then start pulsed mid-run.
        pulse_start(8'h33, 9'd0);
        chk("t6_done0", 512'({bus.done, bus.package_1_valid_out, bus.busy}), 512'(3'b100));
        step();
        chk("t6_done_pulse", 512'(bus.done), 512'(0));
        pulse_start(8'h40, 9'd2);
        for (int i = 0; i < 3; i++) send_beat(64'(i), 0);
        pulse_start(8'h77, 9'd1);
        for (int i = 3; i < 16; i++) send_beat(64'(i), 0);
        chk("t6_addr", 512'({bus.addr_1_out, bus.addr_2_out}), 512'(16'h4041));
        chk("t6_done", 512'(bus.done), 512'(1));
        step();

        // Randomized jobs, including an oversize count that clamps to 256 packages.
        for (int r = 0; r < 5; r++) begin
            logic [8:0] n;
            int nb;
            n  = (r == 4) ? 9'h1F0 : 9'($urandom_range(1, 6));
            nb = ((n > 256) ? 256 : int'(n)) * 8;
            pulse_start(8'($urandom), n);
            for (int i = 0; i < nb; i++)
                send_beat({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            chk("rnd_done", 512'(bus.done), 512'(1));
            repeat ($urandom_range(1, 3)) step();
        end

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
